// File: rtl/periph_ctrl.sv
// ---------------------------------------------------------------------------
// periph_ctrl : memory-mapped peripheral block with a reloading timer, an
// LED register, a seven-segment register and an optional cycle counter.
//
// Register map (byte offsets from BASE_ADDR, addr[1:0] ignored):
//   0x00 TH      rw 32b  timer reload value
//   0x04 TL      rw 32b  timer count
//   0x08 TCON    rw 3b   [0] timer enable, [1] irq enable, [2] irq status
//   0x0C LED     rw 8b
//   0x10 DIGI    rw 12b  [11:8] anode select, [7:0] segments
//   0x14 SYSTICK ro 32b  free-running cycle count, reads 0 when not built
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   addr   in   32b CPU byte address
//   wdata  in   32b store data
//   we     in   store strobe
//   re     in   load strobe
//   rdata  out  32b load data (combinational, 0 when not loading or unmapped)
//   irq    out  TCON[1] & TCON[2], from register state only
//   led    out  8b LED register
//   digi   out  12b seven-segment register
//
// Build option: define PERIPH_SYSTICK_EN to build the SYSTICK counter.
// ---------------------------------------------------------------------------
module periph_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [7:0]  led,
   output logic [11:0] digi
);

   localparam logic [31:0] A_TH   = BASE_ADDR + 32'h00;
   localparam logic [31:0] A_TL   = BASE_ADDR + 32'h04;
   localparam logic [31:0] A_TCON = BASE_ADDR + 32'h08;
   localparam logic [31:0] A_LED  = BASE_ADDR + 32'h0C;
   localparam logic [31:0] A_DIGI = BASE_ADDR + 32'h10;
   localparam logic [31:0] A_TICK = BASE_ADDR + 32'h14;

   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [7:0]  led_q;
   logic [11:0] digi_q;
   logic [31:0] systick;

   logic hit_th, hit_tl, hit_tcon, hit_led, hit_digi, hit_tick;
   logic ovf;
   logic set_sts;
   logic unused_addr_lsb;

   // Word decode: the byte offset within a word does not select anything.
   assign hit_th   = (addr[31:2] == A_TH[31:2]);
   assign hit_tl   = (addr[31:2] == A_TL[31:2]);
   assign hit_tcon = (addr[31:2] == A_TCON[31:2]);
   assign hit_led  = (addr[31:2] == A_LED[31:2]);
   assign hit_digi = (addr[31:2] == A_DIGI[31:2]);
   assign hit_tick = (addr[31:2] == A_TICK[31:2]);
   assign unused_addr_lsb = &{1'b0, addr[1:0]};

   // Overflow is the reload cycle; it raises status only with irq enabled.
   assign ovf     = tcon[0] & (tl == 32'hFFFF_FFFF);
   assign set_sts = ovf & tcon[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th <= '0;
      end else if (we && hit_th) begin
         th <= wdata;
      end
   end

   // A CPU store to TL takes priority over counting in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tl <= '0;
      end else if (we && hit_tl) begin
         tl <= wdata;
      end else if (tcon[0]) begin
         tl <= ovf ? th : tl + 32'd1;
      end
   end

   // Status is sticky: only a store with wdata[2]=0 clears it, and an
   // overflow in the same cycle as that store still wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcon <= '0;
      end else if (we && hit_tcon) begin
         tcon <= {set_sts | wdata[2], wdata[1:0]};
      end else if (set_sts) begin
         tcon[2] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q  <= '0;
         digi_q <= '0;
      end else begin
         if (we && hit_led)  led_q  <= wdata[7:0];
         if (we && hit_digi) digi_q <= wdata[11:0];
      end
   end

`ifdef PERIPH_SYSTICK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
      end
   end
`else
   assign systick = '0;
`endif

   always_comb begin
      rdata = '0;
      if (re) begin
         if (hit_th)        rdata = th;
         else if (hit_tl)   rdata = tl;
         else if (hit_tcon) rdata = {29'd0, tcon};
         else if (hit_led)  rdata = {24'd0, led_q};
         else if (hit_digi) rdata = {20'd0, digi_q};
         else if (hit_tick) rdata = systick;
      end
   end

   assign irq  = tcon[1] & tcon[2];
   assign led  = led_q;
   assign digi = digi_q;

endmodule

// File: tb/tb_periph_ctrl.sv
module tb_periph_ctrl;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;
   logic        irq;
   logic [7:0]  led;
   logic [11:0] digi;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] last_rdata;

   // reference model state
   logic [31:0] m_th, m_tl, m_st;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led;
   logic [11:0] m_digi;

   periph_ctrl #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
      .we(we), .re(re), .rdata(rdata), .irq(irq), .led(led), .digi(digi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Register index from address: word offset from BASE, -1 if unmapped.
   function automatic int m_idx(input logic [31:0] a);
      logic [31:0] off;
      off = {a[31:2], 2'b00} - BASE;
      if (off < 32'd24) return int'(off >> 2);
      return -1;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a);
      case (m_idx(a))
         0: return m_th;
         1: return m_tl;
         2: return {29'd0, m_tcon};
         3: return {24'd0, m_led};
         4: return {20'd0, m_digi};
         5: return m_st;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_st = 0;
   endtask

   task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
      logic        wrap;
      logic        sets;
      logic [31:0] tl_n;
      logic [2:0]  tcon_n;
      wrap   = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      sets   = wrap && m_tcon[1];
      tl_n   = !m_tcon[0] ? m_tl : (wrap ? m_th : m_tl + 1);
      tcon_n = m_tcon | {sets, 2'b00};
      if (w) begin
         case (m_idx(a))
            0: m_th = d;
            1: tl_n = d;
            2: tcon_n = {sets | d[2], d[1:0]};
            3: m_led = d[7:0];
            4: m_digi = d[11:0];
            default: ;
         endcase
      end
      m_tl = tl_n;
      m_tcon = tcon_n;
`ifdef PERIPH_SYSTICK_EN
      m_st = m_st + 1;
`endif
   endtask

   // One bus cycle: drive at negedge, check outputs, advance model at posedge.
   task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = w; re = r; addr = a; wdata = d;
      #1;
      chk("irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
      chk("led", {24'd0, led}, {24'd0, m_led});
      chk("digi", {20'd0, digi}, {20'd0, m_digi});
      chk("rdata", rdata, r ? m_load(a) : 32'd0);
      last_rdata = rdata;
      @(posedge clk);
      m_step(w, a, d);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      cyc(1'b1, 1'b0, BASE + off, d);
   endtask

   task automatic rd(input logic [31:0] off);
      cyc(1'b0, 1'b1, BASE + off, 32'd0);
   endtask

   // Asynchronous reset in mid-cycle with strobes active, released at negedge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      we = 1'b1; re = 1'b1; addr = BASE + 32'h0C; wdata = 32'hFFFF_FFFF;
      reset = 1'b0;
      #1;
      m_reset();
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_led", {24'd0, led}, 32'd0);
      chk("rst_digi", {20'd0, digi}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1; we = 1'b0; re = 1'b0;
   endtask

   initial begin
      logic [31:0] s0, s1, a, d;
      int sel;
      reset = 1'b1; we = 0; re = 0; addr = 0; wdata = 0;
      m_reset();
      do_reset();

      // all six offsets read zero after reset
      for (int i = 0; i < 6; i++) begin
         rd(i * 4);
         chk("init_zero", last_rdata, 32'd0);
      end

      // timer reload and interrupt
      wr(32'h00, 32'hFFFF_FFFC);
      wr(32'h04, 32'hFFFF_FFFE);
      wr(32'h08, 32'h0000_0003);
      rd(32'h04); chk("tl_fe", last_rdata, 32'hFFFF_FFFE);
      rd(32'h04); chk("tl_ff", last_rdata, 32'hFFFF_FFFF);
      rd(32'h04); chk("tl_reload", last_rdata, 32'hFFFF_FFFC);
      chk("irq_set", {31'd0, irq}, 32'd1);
      rd(32'h08); chk("tcon_111", last_rdata, 32'd7);

      // clear status, then overflow coinciding with a TCON store
      wr(32'h08, 32'h0000_0003);
      rd(32'h08); chk("tcon_clr", last_rdata, 32'd3);
      chk("irq_clr", {31'd0, irq}, 32'd0);
      wr(32'h04, 32'hFFFF_FFFF);
      wr(32'h08, 32'h0000_0003);
      rd(32'h08); chk("tcon_ovf_wins", last_rdata, 32'd7);

      // store to TL wins over counting
      wr(32'h04, 32'h0000_0010);
      rd(32'h04); chk("tl_store", last_rdata, 32'h0000_0010);
      rd(32'h04); chk("tl_inc", last_rdata, 32'h0000_0011);

      // LED / DIGI and an unmapped store
      wr(32'h0C, 32'h0000_01A5);
      wr(32'h10, 32'hFFFF_F3F6);
      cyc(1'b0, 1'b0, 32'd0, 32'd0);
      chk("led_a5", {24'd0, led}, 32'h0000_00A5);
      chk("digi_3f6", {20'd0, digi}, 32'h0000_03F6);
      wr(32'h18, 32'hFFFF_FFFF);
      rd(32'h18); chk("unmapped", last_rdata, 32'd0);
      rd(32'h0C); chk("led_kept", last_rdata, 32'h0000_00A5);

      // SYSTICK delta over N cycles
      rd(32'h14); s0 = last_rdata;
      repeat (9) cyc(1'b0, 1'b0, 32'd0, 32'd0);
      rd(32'h14); s1 = last_rdata;
`ifdef PERIPH_SYSTICK_EN
      chk("systick_delta", s1 - s0, 32'd10);
`else
      chk("systick_zero", s1 | s0, 32'd0);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5)      a = BASE + sel * 4 + $urandom_range(0, 3);
         else if (sel == 6) a = BASE + 32'h18;
         else if (sel == 7) a = $urandom;
         else               a = BASE + 32'h04;
         d = $urandom;
         if (sel == 1 && d[0]) d = 32'hFFFF_FFF0 | (d & 32'hF);
         if (sel == 2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         cyc($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, a, d);
      end

      // reset while counting: timer stops and state clears
      wr(32'h08, 32'h0000_0003);
      wr(32'h04, 32'h0000_1234);
      do_reset();
      rd(32'h04); chk("post_rst_tl", last_rdata, 32'd0);
      rd(32'h04); chk("post_rst_hold", last_rdata, 32'd0);
      rd(32'h08); chk("post_rst_tcon", last_rdata, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
